// File: rtl/cpu_step_ctrl_pkg.sv
// Shared types and limits for the CPU step controller.
// Optional feature macro used by the top level: CPU_STEP_CNT_EN (builds step_cnt).
package cpu_step_ctrl_pkg;

  // Controller state codes; the encoding is visible on the state port.
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RUN       = 2'b01,
    STEP_WAIT = 2'b10,
    HALTED    = 2'b11
  } state_t;

  // Legal synchronizer depth range.
  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/sync_rise.sv
// N-flop synchronizer followed by a rising-edge detector on the synchronized level.
module sync_rise #(
  parameter int unsigned STAGES = 2
) (
  input  logic clkin,
  input  logic clr_n,
  input  logic din,
  output logic rise_c
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the asynchronous level in and remember the last synchronized value.
  always_ff @(posedge clkin or negedge clr_n) begin
    if (!clr_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  // Flops reset low, so a level already high at reset release yields one edge.
  assign rise_c = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Turns the divided slow clock into single-cycle CPU enables on the clkin domain,
// with free-run, single-step and halt modes.
// Define CPU_STEP_CNT_EN to build the issued-enable counter; otherwise step_cnt is 0.
module cpu_step_ctrl
  import cpu_step_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clkin,
  input  logic             clr_n,
  input  logic             slow_clk,
  input  logic             mode_run,
  input  logic             step_btn,
  input  logic             halt,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] step_cnt
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("cpu_step_ctrl: SYNC_STAGES must be within 2..4");
  end

  state_t st_q;
  logic   tick_c;
  logic   req_c;
  logic   pulse_c;

  sync_rise #(.STAGES(SYNC_STAGES)) u_sync_slow (
    .clkin  (clkin),
    .clr_n  (clr_n),
    .din    (slow_clk),
    .rise_c (tick_c)
  );

  sync_rise #(.STAGES(SYNC_STAGES)) u_sync_step (
    .clkin  (clkin),
    .clr_n  (clr_n),
    .din    (step_btn),
    .rise_c (req_c)
  );

  // Decide whether this tick becomes an enable; halt and mode exit take precedence.
  always_comb begin
    pulse_c = 1'b0;
    if (!halt && tick_c) begin
      if (st_q == RUN && mode_run) pulse_c = 1'b1;
      if (st_q == STEP_WAIT)       pulse_c = 1'b1;
    end
  end

  // Mode FSM and registered enable pulse.
  always_ff @(posedge clkin or negedge clr_n) begin
    if (!clr_n) begin
      st_q   <= IDLE;
      cpu_en <= 1'b0;
    end else begin
      cpu_en <= pulse_c;
      case (st_q)
        IDLE: begin
          if (halt)          st_q <= HALTED;
          else if (mode_run) st_q <= RUN;
          else if (req_c)    st_q <= STEP_WAIT;
        end
        RUN: begin
          if (halt)           st_q <= HALTED;
          else if (!mode_run) st_q <= IDLE;
        end
        STEP_WAIT: begin
          if (halt)        st_q <= HALTED;
          else if (tick_c) st_q <= IDLE;
        end
        HALTED: begin
          if (!halt) st_q <= IDLE;
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign state = st_q;

`ifdef CPU_STEP_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Count issued enables; wraps naturally at the counter width.
  always_ff @(posedge clkin or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
    end else if (pulse_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign step_cnt = cnt_q;
`else
  assign step_cnt = '0;
`endif

endmodule

// File: doc/cpu_step_ctrl.md
# cpu_step_ctrl

Converts the divided slow clock into single-`clkin`-cycle CPU enable pulses, so the whole microprocessor stays on the fast `clkin` domain. Also provides free-run, single-step and halt modes. It sits directly downstream of the frequency divider: its `slow_clk` input is the divider's `clkout`, and its `cpu_en` output gates every register in the datapath. Both asynchronous inputs (`slow_clk` and `step_btn`) are synchronized and edge-detected internally.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth for `slow_clk` and `step_btn`; legal values are 2 to 4.
- `CNT_W`, default 32: width of the issued-enable counter.

Ports:
- `clkin` in 1: system clock.
- `clr_n` in 1: reset, asynchronous, active-low. Clears all state.
- `slow_clk` in 1: divided clock from the frequency divider; treated as asynchronous.
- `mode_run` in 1: 1 selects free-run; 0 selects single-step.
- `step_btn` in 1: single-step request level; asynchronous, already debounced.
- `halt` in 1: CPU halt indication; synchronous to `clkin`, level.
- `cpu_en` out 1: one-cycle CPU enable pulse; registered.
- `state` out 2: current FSM state code.
- `step_cnt` out `CNT_W`: number of `cpu_en` pulses issued.

## Operation
- **Synchronizers.** `slow_clk` and `step_btn` each pass through `SYNC_STAGES` flops and then a previous-value flop.
  - `tick` = synchronized `slow_clk` high and previous value low.
  - `req` = the same rising-edge detection applied to `step_btn`.
- **FSM states:** IDLE=2'b00, RUN=2'b01, STEP_WAIT=2'b10, HALTED=2'b11.
- **IDLE**
  - `halt`=1 → HALTED.
  - Else `mode_run`=1 → RUN.
  - Else `req` → STEP_WAIT.
  - Else stay in IDLE.
- **RUN**
  - `halt`=1 → HALTED, with no pulse.
  - Else `mode_run`=0 → IDLE, with no pulse.
  - Else `tick` → pulse `cpu_en` and stay in RUN.
  - `req` is ignored.
- **STEP_WAIT**
  - `halt`=1 → HALTED, with no pulse.
  - Else `tick` → pulse `cpu_en` → IDLE.
  - Further `req` edges are ignored; they are not queued.
  - `mode_run` is ignored until the pulse has been issued.
- **HALTED**
  - `cpu_en` is held at 0.
  - `halt`=0 → IDLE.
- **Pulse width.** A pulse means `cpu_en`=1 for exactly one `clkin` cycle, and at most one pulse is issued per `slow_clk` rising edge.
- **Counter.** `step_cnt` increments by 1 in the same cycle that `cpu_en` is driven high. It wraps from 2^`CNT_W`−1 to 0.
- **Reset values:** `cpu_en`=0, `state`=IDLE, `step_cnt`=0, all synchronizer and previous-value flops=0.
- **First edge after reset.** Because all flops reset to 0, a `slow_clk` that is already high at reset release produces exactly one `tick`.

## Timing
- **Latency.** With setup met, a `slow_clk` rising edge produces `cpu_en` high in the cycle after clock edge `SYNC_STAGES`+1. Edges are counted from the first `clkin` rising edge that samples `slow_clk` high. With the default of 2, the latency is 3 `clkin` edges.
- **`step_btn`** has the same synchronizer depth. `req` then affects `state` one edge later.
- **Same-cycle priority:** `halt` > `mode_run` change > `tick`/`req`. A `tick` that is lost to `halt` or to a mode exit is not replayed.
- **Asynchronous reset mid-pulse.** Asserting `clr_n` low during a pulse drops `cpu_en` immediately. Logic resumes on the first `clkin` edge after `clr_n` rises.
- **`slow_clk` rate.** `slow_clk` high and low phases are each at least `SYNC_STAGES`+1 `clkin` cycles; faster inputs are out of contract.

## Configuration
- **`CPU_STEP_CNT_EN` defined:** the `step_cnt` register and its incrementer are built.
- **`CPU_STEP_CNT_EN` undefined:**
  - `step_cnt` is tied to 0 and no counter flops are built.
  - All other behaviour is identical.

## Structure
- **`cpu_step_ctrl_pkg`** holds:
  - the state typedef (2-bit enum) and the constants IDLE, RUN, STEP_WAIT, HALTED;
  - the `SYNC_STAGES` legal-range bounds.
- **`sync_rise`** sub-module:
  - an N-flop synchronizer plus a rising-edge detector, with async active-low reset;
  - instantiated twice, once for `slow_clk` and once for `step_btn`.
- **Top level** contains the FSM, the `cpu_en` register and the optional counter.

## Test plan
- **Reset, free-run entry:** `clr_n` low, then released with `mode_run`=1 and `slow_clk` toggling every 8 `clkin` cycles → `state` goes 00→01. `cpu_en` is a single-cycle pulse 3 edges after each `slow_clk` rise. `step_cnt` reads 4 after 4 rises.
- **Single step:** `mode_run`=0 with one `step_btn` rise → `state`=10. On the next `slow_clk` rise there is exactly one pulse, then `state`=00. A second `step_btn` rise while in 10 adds no extra pulse.
- **Halt wins over tick:** in RUN, assert `halt` in the cycle `tick` fires → `cpu_en` stays 0, `state`=11, `step_cnt` is unchanged. Deassert `halt` → `state`=00.
- **Counter wrap:** with `CNT_W`=4 and the macro defined, 17 pulses → `step_cnt` reads 1. With the macro undefined → `step_cnt` stays 0.
- **Async reset mid-pulse:** pull `clr_n` low while `cpu_en`=1 → `cpu_en`=0 and `state`=00 before the next `clkin` edge.
- **Mode exit race:** in RUN, `mode_run` falls in the same cycle as `tick` → no pulse and `state`=00.
